// File: rtl/bram_fifo_wr_format.sv
// Write-side format/pack stage for the capture BRAM FIFO: normalises ADC lane
// samples (resolution, number format) and packs BRAM_WORD_NUM of them per FIFO word.
module bram_fifo_wr_format #(
    parameter int ADC_MAX_DATA_SIZE = 16,
    parameter int BRAM_WORD_NUM     = 8
) (
    input  logic                                       i_bram_fifo_wr_clk,
    input  logic                                       i_bram_fifo_reset_n,
    input  logic                                       i_fmt_enable,
    input  logic [2:0]                                 i_fmt_capture_mode,
    input  logic [4:0]                                 i_fmt_adc_res,
    input  logic                                       i_fmt_twos_comp,
    input  logic [8*ADC_MAX_DATA_SIZE-1:0]             i_fmt_adc_data,
    input  logic                                       i_fmt_adc_valid,
    input  logic                                       i_bram_fifo_wr_almost_full,
    output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] o_bram_fifo_wr_data,
    output logic                                       o_bram_fifo_wr_clk_en,
    output logic [15:0]                                o_fmt_word_cnt,
    output logic                                       o_fmt_busy,
    output logic                                       o_fmt_done
);
    localparam int W      = ADC_MAX_DATA_SIZE;
    localparam int N      = BRAM_WORD_NUM;
    localparam int LANES  = 8;
    localparam int SLOT_W = $clog2(N);
    localparam logic [SLOT_W-1:0] LAST_SINGLE = SLOT_W'(N - 1);
    localparam logic [SLOT_W-1:0] LAST_OCTAL  = SLOT_W'(N - LANES);
    localparam logic [4:0]        RES_MIN     = 5'd8;
    localparam logic [4:0]        RES_MAX     = 5'(W);
    localparam logic [2:0]        MODE_OCTAL  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_run;
    logic                w_arm;

    logic                r_octal;
    logic [4:0]          r_res;
    logic                r_twos;
    logic [4:0]          w_res_clamped;

    logic                r_s0_valid;
    logic [LANES*W-1:0]  r_s0_data;
    logic [LANES-1:0]    w_sign;
    logic [W-1:0]        w_fmt [LANES];

    logic                r_s1_valid;
    logic [W-1:0]        r_s1_lane [LANES];

    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [N*W-1:0]      r_pack;
    logic [N*W-1:0]      w_pack_next;
    logic                w_word_last;
    logic [N*W-1:0]      r_wr_data;
    logic                r_wr_clk_en;
    logic [15:0]         r_word_cnt;

    // Enable low overrides every transition; DONE is only left through IDLE.
    always_ff @(posedge i_bram_fifo_wr_clk or negedge i_bram_fifo_reset_n) begin
        if (!i_bram_fifo_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_fmt_busy   = 1'b0;
        o_fmt_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_ARM;
            end
            S_ARM: begin
                o_fmt_busy   = 1'b1;
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_fmt_busy = 1'b1;
                if (i_bram_fifo_wr_almost_full) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_fmt_done = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (!i_fmt_enable) begin
            w_state_next = S_IDLE;
        end
    end

    // Every pipeline stage is gated by w_run, so leaving CAPTURE (almost-full or
    // enable low) silently drops whatever is still in flight.
    assign w_run = (r_state == S_CAPTURE) && i_fmt_enable && !i_bram_fifo_wr_almost_full;
    assign w_arm = (r_state == S_ARM);

    always_comb begin
        w_res_clamped = i_fmt_adc_res;
        if (i_fmt_adc_res < RES_MIN) begin
            w_res_clamped = RES_MIN;
        end else if (i_fmt_adc_res > RES_MAX) begin
            w_res_clamped = RES_MAX;
        end
    end

    always_ff @(posedge i_bram_fifo_wr_clk or negedge i_bram_fifo_reset_n) begin
        if (!i_bram_fifo_reset_n) begin
            r_octal <= 1'b0;
            r_res   <= RES_MIN;
            r_twos  <= 1'b0;
        end else if (w_arm) begin
            r_octal <= (i_fmt_capture_mode == MODE_OCTAL);
            r_res   <= w_res_clamped;
            r_twos  <= i_fmt_twos_comp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every stage
    // samples the previous stage's value from before the edge.
    always_ff @(posedge i_bram_fifo_wr_clk or negedge i_bram_fifo_reset_n) begin
        if (!i_bram_fifo_reset_n) begin
            r_s0_valid <= 1'b0;
            r_s0_data  <= '0;
        end else begin
            r_s0_valid <= w_run && i_fmt_adc_valid;
            if (w_run && i_fmt_adc_valid) begin
                r_s0_data <= i_fmt_adc_data;
            end
        end
    end

    // Inverted MSB of the active field, used as the sign for two's complement.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_sign[k] = 1'b0;
            for (int b = 0; b < W; b++) begin
                if (5'(b) == r_res - 5'd1) begin
                    w_sign[k] = ~r_s0_data[k*W+b];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_fmt[k] = '0;
            for (int b = 0; b < W; b++) begin
                if (5'(b) < r_res) begin
                    w_fmt[k][b] = r_s0_data[k*W+b] ^ (r_twos && (5'(b) == r_res - 5'd1));
                end else begin
                    w_fmt[k][b] = r_twos & w_sign[k];
                end
            end
        end
    end

    always_ff @(posedge i_bram_fifo_wr_clk or negedge i_bram_fifo_reset_n) begin
        if (!i_bram_fifo_reset_n) begin
            r_s1_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_s1_lane[k] <= '0;
            end
        end else begin
            r_s1_valid <= r_s0_valid && w_run;
            if (r_s0_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    r_s1_lane[k] <= w_fmt[k];
                end
            end
        end
    end

    // Octal slot counts are always multiples of 8, so a slot belongs to the
    // current beat when its group index matches the counter's.
    always_comb begin
        w_pack_next = r_pack;
        for (int s = 0; s < N; s++) begin
            if (r_octal) begin
                if ((s / LANES) == (int'(r_slot_cnt) / LANES)) begin
                    w_pack_next[s*W +: W] = r_s1_lane[s % LANES];
                end
            end else if (s == int'(r_slot_cnt)) begin
                w_pack_next[s*W +: W] = r_s1_lane[0];
            end
        end
        w_word_last = r_octal ? (r_slot_cnt == LAST_OCTAL) : (r_slot_cnt == LAST_SINGLE);
    end

    always_ff @(posedge i_bram_fifo_wr_clk or negedge i_bram_fifo_reset_n) begin
        if (!i_bram_fifo_reset_n) begin
            r_slot_cnt  <= '0;
            r_pack      <= '0;
            r_wr_data   <= '0;
            r_wr_clk_en <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_wr_clk_en <= 1'b0;
            if (w_arm) begin
                r_slot_cnt <= '0;
                r_word_cnt <= '0;
            end else if (r_s1_valid && w_run) begin
                r_pack <= w_pack_next;
                if (w_word_last) begin
                    r_slot_cnt  <= '0;
                    r_wr_data   <= w_pack_next;
                    r_wr_clk_en <= 1'b1;
                    if (r_word_cnt != 16'hFFFF) begin
                        r_word_cnt <= r_word_cnt + 16'd1;
                    end
                end else begin
                    r_slot_cnt <= r_slot_cnt + (r_octal ? SLOT_W'(LANES) : SLOT_W'(1));
                end
            end
        end
    end

    assign o_bram_fifo_wr_data   = r_wr_data;
    assign o_bram_fifo_wr_clk_en = r_wr_clk_en;
    assign o_fmt_word_cnt        = r_word_cnt;

endmodule

// File: tb/tb_bram_fifo_wr_format.sv
// Self-checking bench for bram_fifo_wr_format: random and directed captures
// compared against a sample-queue reference model of format and packing.
`timescale 1ns/1ps
module tb_bram_fifo_wr_format;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int DW = W * N;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [2:0]      mode = 3'b000;
    logic [4:0]      res = 5'd16;
    logic            twos = 1'b0;
    logic [8*W-1:0]  adc_data = '0;
    logic            adc_valid = 1'b0;
    logic            afull = 1'b0;
    logic [DW-1:0]   wr_data;
    logic            wr_clk_en;
    logic [15:0]     word_cnt;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    bram_fifo_wr_format #(.ADC_MAX_DATA_SIZE(W), .BRAM_WORD_NUM(N)) dut (
        .i_bram_fifo_wr_clk         (clk),
        .i_bram_fifo_reset_n        (rst_n),
        .i_fmt_enable               (en),
        .i_fmt_capture_mode         (mode),
        .i_fmt_adc_res              (res),
        .i_fmt_twos_comp            (twos),
        .i_fmt_adc_data             (adc_data),
        .i_fmt_adc_valid            (adc_valid),
        .i_bram_fifo_wr_almost_full (afull),
        .o_bram_fifo_wr_data        (wr_data),
        .o_bram_fifo_wr_clk_en      (wr_clk_en),
        .o_fmt_word_cnt             (word_cnt),
        .o_fmt_busy                 (busy),
        .o_fmt_done                 (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: formatted samples queue up in arrival order; every N of
    // them form one expected word, due two edges after its last sample edge.
    typedef struct {
        logic [DW-1:0] word;
        int            cyc;
    } exp_t;

    int          cyc = 0;
    bit          model_cap = 1'b0;
    bit          m_octal;
    int          m_res;
    bit          m_twos;
    logic [W-1:0] samp_q[$];
    exp_t        exp_q[$];
    int          words_pushed = 0;
    int          strobes_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fmt(input logic [W-1:0] raw, input int r, input bit tc);
        int rr;
        int unsigned v;
        rr = (r < 8) ? 8 : ((r > W) ? W : r);
        v  = int'(raw) % (1 << rr);
        if (tc) begin
            v = v ^ (1 << (rr - 1));
            if (v >= (1 << (rr - 1))) v = v + ((1 << W) - (1 << rr));
        end
        return W'(v);
    endfunction

    task automatic model_valid(input logic [8*W-1:0] d);
        exp_t e;
        if (!model_cap) return;
        if (m_octal) begin
            for (int k = 0; k < 8; k++) samp_q.push_back(fmt(d[k*W +: W], m_res, m_twos));
        end else begin
            samp_q.push_back(fmt(d[W-1:0], m_res, m_twos));
        end
        while (samp_q.size() >= N) begin
            e.word = '0;
            for (int i = 0; i < N; i++) e.word[i*W +: W] = samp_q.pop_front();
            e.cyc = cyc + 1;
            exp_q.push_back(e);
            words_pushed++;
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (wr_clk_en === 1'b1) begin
            strobes_seen++;
            if (exp_q.size() == 0) begin
                check("stray_strobe", DW'(wr_clk_en), DW'(1'b0));
            end else begin
                e = exp_q.pop_front();
                check("word_data", wr_data, e.word);
                check("word_latency", DW'(cyc - e.cyc), DW'(2));
            end
        end
    end

    function automatic logic [8*W-1:0] rand_lanes();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input logic [8*W-1:0] d, input bit v);
        adc_data  = d;
        adc_valid = v;
        if (v) model_valid(d);
        @(negedge clk);
    endtask

    // Valids are driven during IDLE and ARM on purpose: they must be ignored.
    task automatic start_capture(input logic [2:0] md, input int r, input bit tc);
        @(negedge clk);
        en = 1'b0; afull = 1'b0; adc_valid = 1'b0;
        model_cap = 1'b0;
        @(negedge clk);
        mode = md; res = 5'(r); twos = tc; en = 1'b1;
        samp_q.delete(); exp_q.delete(); words_pushed = 0;
        m_octal = (md == 3'b011); m_res = r; m_twos = tc;
        adc_data = rand_lanes(); adc_valid = 1'b1;
        @(negedge clk);
        adc_data = rand_lanes();
        @(negedge clk);
        adc_valid = 1'b0;
        model_cap = 1'b1;
    endtask

    task automatic end_capture(input string tag);
        adc_valid = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_pending"}, DW'(exp_q.size()), DW'(0));
        check({tag, "_word_cnt"}, DW'(word_cnt), DW'(words_pushed));
    endtask

    logic [DW-1:0] ramp;
    int            af_expected;
    bit            af_raised;

    initial begin
        #1;
        check("rst_data", wr_data, '0);
        check("rst_clk_en", DW'(wr_clk_en), DW'(0));
        check("rst_word_cnt", DW'(word_cnt), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single-mode ramp.
        start_capture(3'b000, 16, 1'b0);
        check("arm_busy", DW'(busy), DW'(1));
        for (int i = 0; i < 8; i++) drive((8*W)'(i), 1'b1);
        end_capture("ramp");
        for (int i = 0; i < N; i++) ramp[i*W +: W] = W'(i);
        check("ramp_word", wr_data, ramp);

        // Octal mode, four back-to-back words.
        start_capture(3'b011, 16, 1'b0);
        begin
            logic [8*W-1:0] d;
            for (int k = 0; k < 8; k++) d[k*W +: W] = W'(16'h0100 + k);
            for (int i = 0; i < 4; i++) drive(d, 1'b1);
        end
        end_capture("octal");

        // Resolution 12, two's complement corner values in slots 0..2.
        start_capture(3'b000, 12, 1'b1);
        drive((8*W)'(16'h0800), 1'b1);
        drive((8*W)'(16'h07FF), 1'b1);
        drive((8*W)'(16'hF000), 1'b1);
        for (int i = 0; i < 5; i++) drive(rand_lanes(), 1'b1);
        end_capture("twos12");
        check("twos12_slot0", DW'(wr_data[0 +: W]), DW'(16'h0000));
        check("twos12_slot1", DW'(wr_data[W +: W]), DW'(16'hFFFF));
        check("twos12_slot2", DW'(wr_data[2*W +: W]), DW'(16'hF800));

        // Partial word abandoned by enable low; next word holds only new samples.
        start_capture(3'b000, 16, 1'b0);
        for (int i = 0; i < 5; i++) drive(rand_lanes(), 1'b1);
        adc_valid = 1'b0; en = 1'b0;
        @(negedge clk);
        check("drop_busy", DW'(busy), DW'(0));
        start_capture(3'b000, 16, 1'b0);
        for (int i = 0; i < 8; i++) drive(rand_lanes(), 1'b1);
        end_capture("reenable");

        // Randomized captures; settings are scrambled mid-capture to prove latching.
        for (int it = 0; it < 8; it++) begin
            int res_pick[6] = '{3, 8, 11, 12, 16, 31};
            start_capture(($urandom_range(0, 1) != 0) ? 3'b011 : 3'(($urandom_range(0, 3) == 0) ? 7 : 1),
                          res_pick[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mode = 3'($urandom); res = 5'($urandom); twos = 1'($urandom);
                end
                drive(rand_lanes(), $urandom_range(0, 9) < 7);
            end
            end_capture("random");
            en = 1'b0;
            @(negedge clk);
            check("random_cnt_hold", DW'(word_cnt), DW'(words_pushed));
        end

        // Continuous octal capture until almost-full at word 100.
        start_capture(3'b011, 16, 1'b0);
        strobes_seen = 0;
        af_raised = 1'b0;
        af_expected = 0;
        for (int c = 0; c < 300 && !af_raised; c++) begin
            if (strobes_seen >= 100) begin
                af_raised   = 1'b1;
                afull       = 1'b1;
                model_cap   = 1'b0;
                af_expected = words_pushed - exp_q.size();
                exp_q.delete();
            end
            drive(rand_lanes(), 1'b1);
        end
        check("af_reached", DW'(af_raised), DW'(1));
        for (int c = 0; c < 10; c++) drive(rand_lanes(), 1'b1);
        check("af_done", DW'(done), DW'(1));
        check("af_busy", DW'(busy), DW'(0));
        check("af_word_cnt", DW'(word_cnt), DW'(af_expected));

        // Asynchronous reset three samples into a word.
        start_capture(3'b000, 16, 1'b0);
        for (int i = 0; i < 3; i++) drive(rand_lanes(), 1'b1);
        adc_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", wr_data, '0);
        check("mid_rst_clk_en", DW'(wr_clk_en), DW'(0));
        check("mid_rst_busy", DW'(busy), DW'(0));
        check("mid_rst_done", DW'(done), DW'(0));
        model_cap = 1'b0;
        samp_q.delete(); exp_q.delete(); words_pushed = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        model_cap = 1'b1;
        for (int i = 0; i < 7; i++) drive(rand_lanes(), 1'b1);
        adc_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_partial", DW'(word_cnt), DW'(0));
        drive(rand_lanes(), 1'b1);
        end_capture("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram_fifo_wr_format.md
# bram_fifo_wr_format

Write-side formatting and packing stage that feeds the main capture BRAM FIFO. It takes per-clock ADC samples (1 or 8 lanes), normalises resolution and number format, and packs BRAM_WORD_NUM samples into one wide word. It presents each packed word on `o_bram_fifo_wr_data` with a one-cycle `o_bram_fifo_wr_clk_en` strobe, and stops issuing words once the FIFO reports almost-full.

## Interface
- ADC_MAX_DATA_SIZE, 16: sample slot width in bits; range 8–16.
- BRAM_WORD_NUM, 8: samples per packed word; power of 2, range 8–64.

Ports:
- i_bram_fifo_wr_clk  in  1  data-rate clock; all logic on its rising edge.
- i_bram_fifo_reset_n  in  1  reset i_bram_fifo_reset_n, asynchronous, active-low; clock i_bram_fifo_wr_clk.
- i_fmt_enable  in  1  capture enable, level; SPI register.
- i_fmt_capture_mode  in  3  000 = single (lane 0), 011 = octal (lanes 0–7); other codes are treated as single.
- i_fmt_adc_res  in  5  actual ADC resolution in bits; clamped to [8, ADC_MAX_DATA_SIZE].
- i_fmt_twos_comp  in  1  1 = convert offset-binary input to two's complement.
- i_fmt_adc_data  in  8*ADC_MAX_DATA_SIZE  lane k at bits [k*ADC_MAX_DATA_SIZE +: ADC_MAX_DATA_SIZE], LSB-justified.
- i_fmt_adc_valid  in  1  lanes valid this cycle.
- i_bram_fifo_wr_almost_full  in  1  from the FIFO; sticky until reset.
- o_bram_fifo_wr_data  out  ADC_MAX_DATA_SIZE*BRAM_WORD_NUM  packed word; reset 0.
- o_bram_fifo_wr_clk_en  out  1  one-cycle strobe qualifying wr_data; reset 0.
- o_fmt_word_cnt  out  16  words emitted since ARM, saturates at 0xFFFF; reset 0.
- o_fmt_busy  out  1  high in ARM or CAPTURE; reset 0.
- o_fmt_done  out  1  high in DONE; reset 0.

## Operation
- FSM states IDLE, ARM, CAPTURE, DONE. Reset state is IDLE.
  - IDLE→ARM on `i_fmt_enable` = 1.
  - ARM→CAPTURE on the next edge, unconditionally.
  - CAPTURE→DONE when `i_bram_fifo_wr_almost_full` = 1.
  - Any state→IDLE when `i_fmt_enable` = 0.
  - DONE stays in DONE until enable drops.
- ARM performs the following:
  - latches mode, res and twos_comp;
  - clears the slot counter, pipeline valids and `o_fmt_word_cnt`.
- Latched settings hold for the whole capture; input changes take effect only at the next ARM.
- Format stage, applied per lane with res r:
  - mask off bits ≥ r;
  - if twos_comp, invert bit r-1 and sign-extend from bit r-1; otherwise zero-extend.
- Pack stage:
  - Single mode: each valid places lane 0 in slot `slot_cnt`, then `slot_cnt` += 1. A word completes after BRAM_WORD_NUM valids.
  - Octal mode: each valid places lanes 0..7 in slots `slot_cnt`..`slot_cnt`+7, then `slot_cnt` += 8. A word completes after BRAM_WORD_NUM/8 valids.
  - Slot 0 occupies the LSBs, so the first sample is in the lowest slot.
  - `slot_cnt` wraps to 0 on completion.
- Samples are accepted only in CAPTURE. Valids in IDLE, ARM or DONE are ignored.
- On completion, the packed word loads into `o_bram_fifo_wr_data` and `o_bram_fifo_wr_clk_en` pulses. `o_fmt_word_cnt` increments on the same edge.
- `o_bram_fifo_wr_data` holds its value between strobes.

## Timing
- The sample that completes a word is sampled at edge T. It is formatted into the stage-1 register at T+1. The word is registered and the strobe asserted at T+2. The strobe is high for exactly one cycle.
- Back-to-back words are supported. In octal mode with BRAM_WORD_NUM = 8, continuous valids give a strobe every cycle.
- When almost_full is sampled high in CAPTURE:
  - the FSM enters DONE on the next edge;
  - no strobe is issued from that edge on, including words already in the pipeline;
  - the partial word is discarded.
- When `i_fmt_enable` drops mid-capture:
  - the FSM goes to IDLE on the next edge;
  - in-flight words are dropped, with no strobe;
  - `o_fmt_word_cnt` holds its value until the next ARM.
- Asynchronous reset mid-word clears all state and outputs immediately, and no strobe is issued.
- Simultaneous completion and almost_full at the same edge: the pipelined word issued at T+2 is still dropped.

## Test plan
- Single mode, r=16, twos_comp=0, ramp 0x0000..0x0007 on lane 0 with valid every cycle → one strobe, wr_data = {0x0007,…,0x0001,0x0000}, 2 cycles after the 8th valid; word_cnt=1.
- Octal mode, BRAM_WORD_NUM=8, lanes k=0x0100+k, valid for 4 cycles → 4 consecutive strobes, each word = {0x0107..0x0100}; word_cnt=4.
- r=12, twos_comp=1, input 0x0800 → slot 0x0000; input 0x07FF → 0xFFFF; input 0xF000 (above res) → 0xF800 (masked to 0x000, then MSB inverted and sign-extended).
- Single mode, 5 valids, then enable low, then re-enable and 8 valids → no strobe from the first 5 samples; next word contains only the new 8 samples.
- Continuous octal capture, almost_full raised at word 100 → at most 2 further strobes are suppressed, FSM in DONE, o_fmt_done=1, no strobes thereafter.
- Reset asserted 3 samples into a word → all outputs 0 immediately, FSM IDLE; after release with enable high, the first strobe appears only after a full 8-sample word.
